// File: rtl/sipo_load_controller_pkg.sv
// Shared types and defaults for the serial-to-parallel load controller.
package sipo_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      HIGH,
      LATCH
   } state_t;

   localparam int WIDTH_DEF  = 8;
   localparam int CLKDIV_DEF = 2;

endpackage

// File: rtl/sipo_load_controller_tick_gen.sv
// Phase divider: counts system-clock cycles within one sclk phase and
// flags the last cycle of the phase so the FSM knows when to move on.
module sipo_tick_gen #(
   parameter int CLKDIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = $clog2(CLKDIV + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

   logic [CW-1:0] count;

   // The tick is suppressed while cleared so an idle controller never sees a phase end.
   assign tick = !clear && (count == LAST);

   // Count up through one phase, restarting on every phase boundary or while held clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sipo_load_controller.sv
// Serialises parallel words into an external shift/latch register:
// one data bit and one sclk pulse per bit, then a single slatch pulse.
// Every output is registered from the state of the previous cycle, so the
// pins trail the internal state by exactly one system clock.
module sipo_load_controller
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int CLKDIV    = CLKDIV_DEF,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sdata,
   output logic             sclk,
   output logic             slatch,
   output logic             busy,
   output logic             done
);

   localparam int            BW       = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shift_buf;
   logic [BW-1:0]    bit_cnt;
   logic             tick;
   logic             accept;
   logic             cur_bit;
   logic             was_latch;

   // in_ready is only ever high while the FSM sits in IDLE, so it alone qualifies an accept.
   assign accept  = in_valid && in_ready;
   assign cur_bit = MSB_FIRST ? shift_buf[WIDTH-1] : shift_buf[0];

   sipo_tick_gen #(
      .CLKDIV (CLKDIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clear (state == IDLE),
      .tick  (tick)
   );

   // Sequencer: walks SETUP/HIGH once per bit, then LATCH, and registers all pin values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_buf <= '0;
         bit_cnt   <= '0;
         was_latch <= 1'b0;
         sdata     <= 1'b0;
         sclk      <= 1'b0;
         slatch    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         sclk      <= (state == HIGH);
         slatch    <= (state == LATCH);
         busy      <= (state != IDLE);
         was_latch <= (state == LATCH);
         done      <= (state == IDLE) && was_latch;
         in_ready  <= (state == IDLE) && !accept;
         if (state == SETUP) begin
            sdata <= cur_bit;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  shift_buf <= in_data;
                  bit_cnt   <= '0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (tick) begin
                  state <= HIGH;
               end
            end
            HIGH: begin
               if (tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     state <= LATCH;
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     shift_buf <= MSB_FIRST ? (shift_buf << 1) : (shift_buf >> 1);
                     state     <= SETUP;
                  end
               end
            end
            LATCH: begin
               if (tick) begin
                  bit_cnt <= '0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sipo_load_controller.md
Name: sipo_load_controller

Overview:
- Sequences an external serial-to-parallel shift/latch register (8-bit shift chain plus separate output latch strobe).
- Accepts parallel words on a valid/ready handshake and serialises each word as a data bit, a shift-clock pulse per bit, and one latch pulse at the end.
- Sits between the system-clock control logic and the shift-register datapath.
- All outputs are registered and derived from the single system clock.

Parameters:
- WIDTH, 8, bits per word; one shift pulse per bit; minimum 1.
- CLKDIV, 2, system-clock cycles per half-period of sclk; also the slatch high time; minimum 1.
- MSB_FIRST, 0, 0 = bit 0 shifted first (ends in the LSB of a right-shifting chain fed at its MSB); 1 = bit WIDTH-1 first.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  word to send; sampled only on accept.
- in_valid  in  1  word available.
- in_ready  out  1  controller can accept; high only in IDLE.
- sdata  out  1  serial data to the shift register.
- sclk  out  1  shift clock; the shift register samples sdata on its rising edge.
- slatch  out  1  latch strobe; the shift register transfers to its output latch on its rising edge.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse after slatch falls.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-word):
  - sdata=0, sclk=0, slatch=0, busy=0, done=0, in_ready=1 once reset deasserts.
  - State=IDLE, all counters=0, shift buffer=0.
  - A partial word is discarded; no latch pulse is produced.
- Accept: rising edge with in_valid=1 and in_ready=1.
  - in_data is copied to the internal shift buffer.
  - Next state SETUP, bit count 0, div count 0.
- States:
  - IDLE: sclk=0, slatch=0, sdata holds its last value (0 after reset). On accept -> SETUP.
  - SETUP: sdata = current bit, sclk=0, held CLKDIV cycles -> HIGH.
  - HIGH: sdata unchanged, sclk=1, held CLKDIV cycles.
    - If this is not the last bit: shift buffer one place, bit count +1 -> SETUP.
    - If bit count = WIDTH-1 -> LATCH.
  - LATCH: sclk=0, sdata unchanged, slatch=1, held CLKDIV cycles -> IDLE.
- done: asserted for exactly the first IDLE cycle following LATCH.
  - in_ready is also high in that cycle, so back-to-back words are allowed.
  - Minimum inter-word gap is 1 IDLE cycle.
- Timing:
  - sdata changes only on SETUP entry, giving CLKDIV cycles of setup before each sclk rise.
  - sdata is held through the sclk high phase and through LATCH.
- Latency:
  - Busy time per word = 2*CLKDIV*WIDTH + CLKDIV cycles, counted from the cycle after accept.
  - First sclk rise occurs CLKDIV+1 cycles after the accept edge.
- Counters:
  - Divider counter width is $clog2(CLKDIV+1) and wraps to 0 on each state change.
  - Bit counter width is $clog2(WIDTH+1) and never exceeds WIDTH-1.
- Handshake rules:
  - in_valid while busy is ignored; in_data may change freely.
  - in_valid dropping mid-word has no effect.
- CLKDIV=1: SETUP, HIGH and LATCH each last 1 cycle; sclk toggles every cycle.
- Exactly WIDTH sclk rises and exactly 1 slatch rise per accepted word; never any sclk pulse while slatch=1.

Decomposition:
- Package sipo_ctrl_pkg:
  - typedef enum state_t {IDLE, SETUP, HIGH, LATCH}.
  - Parameter defaults WIDTH_DEF=8 and CLKDIV_DEF=2.
- Sub-module sipo_tick_gen:
  - Divider counter with a clear input.
  - Outputs a one-cycle tick when the count reaches CLKDIV-1.
- FSM, bit counter and shift buffer remain in the top module.

Test Plan:
- Reset then single word, WIDTH=8, CLKDIV=2, in_data=8'hA5, MSB_FIRST=0:
  - sdata at the 8 sclk rises = 1,0,1,0,0,1,0,1.
  - One slatch pulse 2 cycles wide; done pulses exactly 35 cycles after the accept edge.
  - A behavioural right-shift/latch model fed by the outputs reads 8'hA5.
- Back-to-back, in_valid held with 8'h01 then 8'hFF:
  - Second accept occurs on the done cycle.
  - Model shows 8'h01 then 8'hFF; 16 sclk rises and 2 slatch rises total.
- MSB_FIRST=1, in_data=8'h80:
  - First sdata sampled = 1, remaining 7 = 0.
- Reset asserted during bit 4 of 8'h3C:
  - All outputs drop to 0 in the same cycle (asynchronous).
  - No slatch pulse occurs.
  - After release, 8'hC3 sends cleanly and the model reads 8'hC3.
- CLKDIV=1, in_data=8'h55:
  - sclk period is 2 cycles; busy is high for 17 cycles.
  - in_data changed and in_valid toggled mid-word have no effect on the output.
- WIDTH=1, in_data=1'b1:
  - Exactly 1 sclk rise, then slatch; done follows 3*CLKDIV+1 cycles after accept.
